// File: rtl/video_frame_source.sv
// 800x525 raster generator that streams a ROM image into a centred window for the edge filter.
// Pipeline: counters -> ROM read stage -> output register; syncs get SYNC_DELAY more stages.
module video_frame_source #(
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter int         WIDTH      = 534,
    parameter int         HEIGHT     = 400,
    parameter int         SYNC_DELAY = 3,
    parameter logic [7:0] BG         = 8'd0,
    localparam int        AW         = $clog2(WIDTH * HEIGHT)
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          pattern_sel,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [7:0]    pixel_out,
    output logic [9:0]    h_pos,
    output logic [9:0]    v_pos,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N_W     = (H_ACTIVE - WIDTH) / 2;
    localparam int N_H     = (V_ACTIVE - HEIGHT) / 2;

    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    WIN_H0    = 10'(N_W);
    localparam logic [9:0]    WIN_H1    = 10'(N_W + WIDTH);
    localparam logic [9:0]    WIN_V0    = 10'(N_H);
    localparam logic [9:0]    WIN_V1    = 10'(N_H + HEIGHT);
    localparam logic [9:0]    HS0       = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS1       = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS0       = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS1       = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    HA        = 10'(H_ACTIVE);
    localparam logic [9:0]    VA        = 10'(V_ACTIVE);
    localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH * HEIGHT - 1);

    logic [9:0] h_cnt, v_cnt;
    logic       pattern;
    logic       in_win, at_origin, at_end;

    // Stage 1: counter position travelling alongside the ROM read.
    logic       s1_vld, s1_win;
    logic [9:0] s1_h, s1_v;

    logic [7:0] pix_next;
    logic       fs_next, hs_next, vs_next, de_next;
    logic       hs_a, vs_a, de_a;

    always_comb begin
        // NOTE: every output of this block gets a value before any condition, so no latch is inferred.
        pix_next  = BG;
        in_win    = (h_cnt >= WIN_H0) && (h_cnt < WIN_H1) && (v_cnt >= WIN_V0) && (v_cnt < WIN_V1);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        if (s1_win) pix_next = pattern ? s1_h[7:0] : rom_data;
        fs_next   = s1_vld && (s1_h == '0) && (s1_v == '0);
        hs_next   = !(s1_vld && (s1_h >= HS0) && (s1_h < HS1));
        vs_next   = !(s1_vld && (s1_v >= VS0) && (s1_v < VS1));
        de_next   = s1_vld && (s1_h < HA) && (s1_v < VA);
    end

    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            rom_addr <= '0;
            pattern  <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (at_end)      rom_addr <= '0;
            else if (in_win) rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + AW'(1);
            if (at_origin)   pattern  <= pattern_sel;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_win <= 1'b0;
            s1_h   <= '0;
            s1_v   <= '0;
        end else begin
            s1_vld <= 1'b1;
            s1_win <= in_win;
            s1_h   <= h_cnt;
            s1_v   <= v_cnt;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pixel_out   <= 8'd0;
            h_pos       <= '0;
            v_pos       <= '0;
            frame_start <= 1'b0;
            hs_a        <= 1'b1;
            vs_a        <= 1'b1;
            de_a        <= 1'b0;
        end else begin
            pixel_out   <= pix_next;
            h_pos       <= s1_h;
            v_pos       <= s1_v;
            frame_start <= fs_next;
            hs_a        <= hs_next;
            vs_a        <= vs_next;
            de_a        <= de_next;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync = hs_a;
            assign vsync = vs_a;
            assign de    = de_a;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_d, vs_d, de_d;
            always_ff @(posedge pixel_clk) begin
                if (rst) begin
                    hs_d <= '1;
                    vs_d <= '1;
                    de_d <= '0;
                end else begin
                    hs_d[0] <= hs_a;
                    vs_d[0] <= vs_a;
                    de_d[0] <= de_a;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_d[i] <= hs_d[i-1];
                        vs_d[i] <= vs_d[i-1];
                        de_d[i] <= de_d[i-1];
                    end
                end
            end
            assign hsync = hs_d[SYNC_DELAY-1];
            assign vsync = vs_d[SYNC_DELAY-1];
            assign de    = de_d[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_video_frame_source.sv
// Bench for video_frame_source: two full-size instances (sync delay 3 and 0) plus a scaled-down
// raster for multi-frame behaviour, checked every cycle against a closed-form raster model.
module tb_video_frame_source;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int w;  int h;   int d;
    } geo_t;

    typedef struct packed {
        logic [17:0] addr;
        logic [7:0]  pix;
        logic [9:0]  hp;
        logic [9:0]  vp;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    localparam geo_t G_A = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, w:534, h:400, d:3};
    localparam geo_t G_B = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, w:534, h:400, d:0};
    localparam geo_t G_S = '{ha:64,  hfp:4,  hs:8,  hbp:4,  va:48,  vfp:2,  vs:2, vbp:3,  w:40,  h:30,  d:3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, rst_s, pat_d, pat_s;
    logic [17:0] ra_a, ra_b;
    logic [10:0] ra_s;
    logic [7:0]  rd_a, rd_b, rd_s, px_a, px_b, px_s;
    logic [9:0]  hp_a, vp_a, hp_b, vp_b, hp_s, vp_s;
    logic        hs_a, vs_a, de_a, fs_a;
    logic        hs_b, vs_b, de_b, fs_b;
    logic        hs_s, vs_s, de_s, fs_s;

    video_frame_source #(.SYNC_DELAY(3)) dut_a (
        .pixel_clk(clk), .rst(rst_d), .pattern_sel(pat_d), .rom_addr(ra_a), .rom_data(rd_a),
        .pixel_out(px_a), .h_pos(hp_a), .v_pos(vp_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .frame_start(fs_a));

    video_frame_source #(.SYNC_DELAY(0)) dut_b (
        .pixel_clk(clk), .rst(rst_d), .pattern_sel(pat_d), .rom_addr(ra_b), .rom_data(rd_b),
        .pixel_out(px_b), .h_pos(hp_b), .v_pos(vp_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .frame_start(fs_b));

    video_frame_source #(
        .H_ACTIVE(G_S.ha), .H_FP(G_S.hfp), .H_SYNC(G_S.hs), .H_BP(G_S.hbp),
        .V_ACTIVE(G_S.va), .V_FP(G_S.vfp), .V_SYNC(G_S.vs), .V_BP(G_S.vbp),
        .WIDTH(G_S.w), .HEIGHT(G_S.h), .SYNC_DELAY(G_S.d)
    ) dut_s (
        .pixel_clk(clk), .rst(rst_s), .pattern_sel(pat_s), .rom_addr(ra_s), .rom_data(rd_s),
        .pixel_out(px_s), .h_pos(hp_s), .v_pos(vp_s), .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .frame_start(fs_s));

    // Synchronous image ROMs holding rom[a] = a[7:0].
    always @(posedge clk) begin
        rd_a <= ra_a[7:0];
        rd_b <= ra_b[7:0];
        rd_s <= ra_s[7:0];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, expv);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic int frame_len(input geo_t g);
        return (g.ha + g.hfp + g.hs + g.hbp) * (g.va + g.vfp + g.vs + g.vbp);
    endfunction

    // Expected outputs during the cycle whose counter position is cyc raster steps after reset.
    function automatic exp_t model(input geo_t g, input int cyc, input logic pat);
        exp_t e;
        int ht, ft, nw, nh, q, h, v, cnt, ps;
        ht = g.ha + g.hfp + g.hs + g.hbp;
        ft = frame_len(g);
        nw = (g.ha - g.w) / 2;
        nh = (g.va - g.h) / 2;
        e  = '{addr:'0, pix:'0, hp:'0, vp:'0, fs:1'b0, hs:1'b1, vs:1'b1, de:1'b0};
        q = cyc % ft; h = q % ht; v = q / ht;
        if (v >= nh && v < nh + g.h) begin
            cnt = (v - nh) * g.w + ((h < nw) ? 0 : (h >= nw + g.w) ? g.w : h - nw);
            if (cnt == g.w * g.h) cnt = 0;
            e.addr = 18'(cnt);
        end
        if (cyc >= 2) begin
            q = (cyc - 2) % ft; h = q % ht; v = q / ht;
            e.hp = 10'(h);
            e.vp = 10'(v);
            e.fs = (q == 0);
            if (h >= nw && h < nw + g.w && v >= nh && v < nh + g.h)
                e.pix = pat ? 8'(h) : 8'((v - nh) * g.w + (h - nw));
        end
        ps = cyc - 2 - g.d;
        if (ps >= 0) begin
            q = ps % ft; h = q % ht; v = q / ht;
            e.hs = !(h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs);
            e.vs = !(v >= g.va + g.vfp && v < g.va + g.vfp + g.vs);
            e.de = (h < g.ha) && (v < g.va);
        end
        return e;
    endfunction

    int   cyc [3] = '{0, 0, 0};
    logic patf [3][16];
    int   max_s = 0;

    task automatic step(input int i, input geo_t g, input logic r, input logic psel,
                        input exp_t act, input string nm);
        int   ft;
        logic p;
        exp_t e;
        ft = frame_len(g);
        if (r) cyc[i] = 0;
        else begin
            if (cyc[i] % ft == 0) patf[i][(cyc[i] / ft) % 16] = psel;
            cyc[i]++;
        end
        p = (cyc[i] >= 2) ? patf[i][((cyc[i] - 2) / ft) % 16] : 1'b0;
        e = model(g, cyc[i], p);
        check(nm, cyc[i], 64'(act), 64'(e));
    endtask

    // Compare process: every instance, every cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        step(0, G_A, rst_d, pat_d, exp_t'({ra_a, px_a, hp_a, vp_a, fs_a, hs_a, vs_a, de_a}), "model_a");
        step(1, G_B, rst_d, pat_d, exp_t'({ra_b, px_b, hp_b, vp_b, fs_b, hs_b, vs_b, de_b}), "model_b");
        step(2, G_S, rst_s, pat_s, exp_t'({7'd0, ra_s, px_s, hp_s, vp_s, fs_s, hs_s, vs_s, de_s}), "model_s");
        if (!rst_s && int'(ra_s) > max_s) max_s = int'(ra_s);
    end

    function automatic logic [19:0] pos_of(input int sel);
        case (sel)
            0:       return {hp_a, vp_a};
            1:       return {hp_b, vp_b};
            default: return {hp_s, vp_s};
        endcase
    endfunction

    function automatic logic [7:0] pix_of(input int sel);
        case (sel)
            0:       return px_a;
            1:       return px_b;
            default: return px_s;
        endcase
    endfunction

    function automatic logic hs_of(input int sel);
        case (sel)
            0:       return hs_a;
            1:       return hs_b;
            default: return hs_s;
        endcase
    endfunction

    task automatic wait_pos(input int sel, input int x, input int y, input string name);
        bit found = 0;
        for (int n = 0; n < 60000 && !found; n++) begin
            @(posedge clk); #1;
            if (pos_of(sel) == {10'(x), 10'(y)}) found = 1;
        end
        if (!found) timeout(name);
    endtask

    task automatic pix_at(input int sel, input int x, input int y, input logic [7:0] want, input string name);
        wait_pos(sel, x, y, name);
        check(name, x, pix_of(sel), want);
    endtask

    task automatic wait_hs_fall(input int sel, input string name);
        bit   found = 0;
        logic prev;
        prev = hs_of(sel);
        for (int n = 0; n < 2000 && !found; n++) begin
            @(posedge clk); #1;
            if (prev && !hs_of(sel)) found = 1;
            prev = hs_of(sel);
        end
        if (!found) timeout(name);
    endtask

    task automatic flow_full;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        wait_hs_fall(1, "hs_fall_d0");
        check("hs_fall_d0", 0, hp_b, 10'd656);
        wait_hs_fall(0, "hs_fall_d3");
        check("hs_fall_d3", 0, hp_a, 10'd659);
        pix_at(0, 52, 40, 8'h00, "pix_52_40");
        pix_at(0, 53, 40, 8'h00, "pix_53_40");
        pix_at(0, 54, 40, 8'h01, "pix_54_40");
        pix_at(0, 53, 41, 8'h16, "pix_53_41");
    endtask

    task automatic flow_small;
        int  fs_cnt = 0, hs_low = 0, vs_low = 0, de_cnt = 0;
        bit  found = 0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 4400; n++) begin
            fs_cnt += int'(fs_s);
            hs_low += int'(!hs_s);
            vs_low += int'(!vs_s);
            de_cnt += int'(de_s);
            @(posedge clk); #1;
        end
        check("frame_starts", 0, 64'(fs_cnt), 64'd1);
        check("hsync_low",    0, 64'(hs_low), 64'd440);
        check("vsync_low",    0, 64'(vs_low), 64'd160);
        check("de_high",      0, 64'(de_cnt), 64'd3072);
        // Frame 1: window corners from the ROM, first pixel re-reads address 0.
        pix_at(2, 11, 9,  8'h00, "s_pix_11_9");
        pix_at(2, 12, 9,  8'h00, "s_pix_12_9");
        pix_at(2, 13, 9,  8'h01, "s_pix_13_9");
        pix_at(2, 12, 10, 8'h28, "s_pix_12_10");
        pix_at(2, 51, 38, 8'hAF, "s_pix_51_38");
        pix_at(2, 52, 38, 8'h00, "s_pix_52_38");
        // Frame 2: switch to the ramp mid-frame; the frame must finish from the ROM.
        wait_pos(2, 30, 20, "s_toggle");
        @(negedge clk);
        pat_s = 1'b1;
        pix_at(2, 51, 38, 8'hAF, "s_pix_51_38_f2");
        pix_at(2, 5,  20, 8'h00, "s_ramp_5_20");
        pix_at(2, 20, 20, 8'h14, "s_ramp_20_20");
        // Frame 3: mid-frame reset, then the raster restarts at the origin.
        wait_pos(2, 30, 20, "s_reset_pt");
        @(negedge clk);
        rst_s = 1'b1;
        pat_s = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("in_reset", n, {hp_s, vp_s, px_s, hs_s, vs_s, de_s, fs_s, ra_s},
                  {10'd0, 10'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0});
        end
        @(negedge clk);
        rst_s = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(posedge clk); #1;
            if (fs_s) found = 1;
        end
        if (!found) timeout("restart_fs");
        check("restart_pos", 0, {hp_s, vp_s, ra_s}, {10'd0, 10'd0, 11'd0});
        @(posedge clk); #1;
        check("restart_pos", 1, {hp_s, vp_s}, {10'd1, 10'd0});
        @(posedge clk); #1;
        check("restart_pos", 2, {hp_s, vp_s}, {10'd2, 10'd0});
        pix_at(2, 12, 9, 8'h00, "s_restart_12_9");
        pix_at(2, 13, 9, 8'h01, "s_restart_13_9");
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        pat_d = 1'b0;
        pat_s = 1'b0;
        fork
            flow_full();
            flow_small();
        join
        check("rom_addr_max", 0, 64'(max_s), 64'd1199);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
